// File: rtl/dp_tile_sequencer.sv
// Per-channel sequencer for the depthwise/pointwise data path: walks num_ch channel maps,
// issuing weight/data fetch inits, holding data_load per map and checking the tile count.
//
// state | meaning
// IDLE  | waiting for start; config latched on an accepted start
// LOAD  | one-cycle fetch-init pulses with the current channel addresses
// RUN   | data path running the map; blkend counted until mapend
// NEXT  | one-cycle channel advance, or finish on the last channel
// DONE  | one-cycle done pulse
module dp_tile_sequencer #(
    parameter int AW     = 32,
    parameter int CHW    = 11,
    parameter int IW     = 224,
    parameter int IH     = 224,
    parameter int POX    = 15,
    parameter int POY    = 3,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 2,
    parameter int DBYTES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic           mode,
    input  logic [CHW-1:0] num_ch,
    input  logic [AW-1:0]  data_base,
    input  logic [AW-1:0]  weight_base,
    input  logic [AW-1:0]  ch_stride,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [CHW-1:0] ch_idx,
    output logic [1:0]     dw_comp,
    output logic           data_load,
    output logic [AW-1:0]  data_init_addr,
    output logic           data_init_addr_en,
    output logic           weight_load,
    output logic [AW-1:0]  weight_init_addr,
    input  logic           blkend,
    input  logic           mapend
);

    localparam int OW_DW   = (IW - KSIZE) / STRIDE + 1;
    localparam int OH_DW   = (IH - KSIZE) / STRIDE + 1;
    localparam int NBLK_DW = ((OW_DW + POX - 1) / POX) * ((OH_DW + POY - 1) / POY);
    localparam int NBLK_PW = ((IW + POX - 1) / POX) * ((IH + POY - 1) / POY);
    localparam int BW      = 16;

    localparam logic [BW-1:0] NBLK_DW_C  = BW'(NBLK_DW);
    localparam logic [BW-1:0] NBLK_PW_C  = BW'(NBLK_PW);
    localparam logic [AW-1:0] WSTEP_DW_C = AW'(KSIZE * KSIZE * DBYTES);
    localparam logic [AW-1:0] WSTEP_PW_C = AW'(DBYTES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RUN  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state;
    logic            mode_q;
    logic            run_q;
    logic [CHW-1:0]  num_ch_q;
    logic [AW-1:0]   stride_q;
    logic [BW-1:0]   blk_cnt;
    logic [BW-1:0]   blk_nxt;
    logic [BW-1:0]   nblk;
    logic [AW-1:0]   wstep;

    assign dw_comp = {run_q, mode_q};
    assign nblk    = mode_q ? NBLK_PW_C : NBLK_DW_C;
    assign wstep   = mode_q ? WSTEP_PW_C : WSTEP_DW_C;

    // Saturating count so a runaway blkend stream cannot wrap back onto NBLK.
    always_comb begin
        blk_nxt = blk_cnt;
        if (blkend && (blk_cnt != {BW{1'b1}})) begin
            blk_nxt = blk_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            mode_q            <= 1'b0;
            run_q             <= 1'b0;
            num_ch_q          <= '0;
            stride_q          <= '0;
            blk_cnt           <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            ch_idx            <= '0;
            data_load         <= 1'b0;
            data_init_addr    <= '0;
            data_init_addr_en <= 1'b0;
            weight_load       <= 1'b0;
            weight_init_addr  <= '0;
        end else begin
            data_init_addr_en <= 1'b0;
            weight_load       <= 1'b0;
            done              <= 1'b0;
            if (abort) begin
                // Abort wins over everything; err and ch_idx are left as they were.
                if (state != IDLE) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    data_load <= 1'b0;
                    run_q     <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_ch == '0) begin
                                err <= 1'b1;
                            end else begin
                                mode_q            <= mode;
                                num_ch_q          <= num_ch;
                                stride_q          <= ch_stride;
                                data_init_addr    <= data_base;
                                weight_init_addr  <= weight_base;
                                err               <= 1'b0;
                                ch_idx            <= '0;
                                blk_cnt           <= '0;
                                busy              <= 1'b1;
                                data_init_addr_en <= 1'b1;
                                weight_load       <= 1'b1;
                                state             <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        blk_cnt   <= '0;
                        data_load <= 1'b1;
                        run_q     <= 1'b1;
                        state     <= RUN;
                    end
                    RUN: begin
                        blk_cnt <= blk_nxt;
                        if (mapend) begin
                            if (blk_nxt != nblk) begin
                                err <= 1'b1;
                            end
                            data_load <= 1'b0;
                            run_q     <= 1'b0;
                            state     <= NEXT;
                        end
                    end
                    NEXT: begin
                        if (ch_idx == num_ch_q - CHW'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ch_idx            <= ch_idx + CHW'(1);
                            data_init_addr    <= data_init_addr + stride_q;
                            weight_init_addr  <= weight_init_addr + wstep;
                            data_init_addr_en <= 1'b1;
                            weight_load       <= 1'b1;
                            state             <= LOAD;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy      <= 1'b0;
                        data_load <= 1'b0;
                        run_q     <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dp_tile_sequencer.sv
// Directed bench for dp_tile_sequencer: DW/PW channel walks, tile-count errors, abort,
// illegal num_ch, address wrap and async reset, against hand-computed values.
module tb_dp_tile_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [10:0] num_ch;
    logic [31:0] data_base;
    logic [31:0] weight_base;
    logic [31:0] ch_stride;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] ch_idx;
    logic [1:0]  dw_comp;
    logic        data_load;
    logic [31:0] data_init_addr;
    logic        data_init_addr_en;
    logic        weight_load;
    logic [31:0] weight_init_addr;
    logic        blkend;
    logic        mapend;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    dp_tile_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .abort             (abort),
        .mode              (mode),
        .num_ch            (num_ch),
        .data_base         (data_base),
        .weight_base       (weight_base),
        .ch_stride         (ch_stride),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .ch_idx            (ch_idx),
        .dw_comp           (dw_comp),
        .data_load         (data_load),
        .data_init_addr    (data_init_addr),
        .data_init_addr_en (data_init_addr_en),
        .weight_load       (weight_load),
        .weight_init_addr  (weight_init_addr),
        .blkend            (blkend),
        .mapend            (mapend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic m, input logic [10:0] n, input logic [31:0] db,
                          input logic [31:0] wb, input logic [31:0] cs);
        mode        = m;
        num_ch      = n;
        data_base   = db;
        weight_base = wb;
        ch_stride   = cs;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // n blkend pulses then one mapend; returns just after the edge that enters NEXT.
    task automatic run_map(input int n);
        for (int i = 0; i < n; i++) begin
            blkend = 1'b1;
            tick();
        end
        blkend = 1'b0;
        mapend = 1'b1;
        tick();
        mapend = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; num_ch = '0;
        data_base = '0; weight_base = '0; ch_stride = '0; blkend = 1'b0; mapend = 1'b0;
        #23;
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {done, err, data_load, data_init_addr_en, weight_load, dw_comp}, 0);
        chk("rst_ch_idx", ch_idx, 0);
        chk("rst_addrs", {data_init_addr, weight_init_addr}, 0);
        tick();

        // DW, two channels, exact tile counts
        launch(1'b0, 11'd2, 32'h1000, 32'h8000, 32'hC400);
        chk("t1_load_pulses", {data_init_addr_en, weight_load, busy}, 3'b111);
        chk("t1_daddr0", data_init_addr, 32'h1000);
        chk("t1_waddr0", weight_init_addr, 32'h8000);
        tick();
        chk("t1_run", {data_load, dw_comp}, 3'b110);
        run_map(296);
        chk("t1_next", {data_load, data_init_addr_en, done}, 0);
        tick();
        chk("t1_load1_en", {data_init_addr_en, weight_load}, 2'b11);
        chk("t1_daddr1", data_init_addr, 32'hD400);
        chk("t1_waddr1", weight_init_addr, 32'h8024);
        chk("t1_ch1", ch_idx, 1);
        tick();
        run_map(296);
        chk("t1_no_early_done", done, 0);
        tick();
        chk("t1_done", {done, err, busy}, 3'b101);
        tick();
        chk("t1_idle", {done, busy}, 0);
        chk("t1_done_cnt", done_cnt, 1);

        // illegal num_ch
        launch(1'b0, 11'd0, 32'h0, 32'h0, 32'h0);
        chk("t2_err", err, 1);
        chk("t2_quiet", {busy, data_init_addr_en, weight_load}, 0);
        tick();
        chk("t2_stay_idle", {busy, data_init_addr_en}, 0);

        // short tile count on channel 0
        launch(1'b0, 11'd2, 32'h2000, 32'h100, 32'h10);
        chk("t3_err_cleared", err, 0);
        tick();
        run_map(295);
        chk("t3_err_set", err, 1);
        tick();
        chk("t3_ch1", ch_idx, 1);
        chk("t3_addrs", {data_init_addr, weight_init_addr}, {32'h2010, 32'h124});
        tick();
        run_map(296);
        tick();
        chk("t3_done_err", {done, err}, 2'b11);
        tick();

        // abort with same-cycle blkend, then stray mapend in IDLE
        launch(1'b0, 11'd2, 32'h3000, 32'h0, 32'h100);
        chk("t4_err_cleared", err, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            blkend = 1'b1;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        blkend = 1'b0;
        chk("t4_abort", {busy, data_load, dw_comp}, 0);
        chk("t4_ch_frozen", ch_idx, 0);
        mapend = 1'b1;
        blkend = 1'b1;
        tick();
        mapend = 1'b0;
        blkend = 1'b0;
        chk("t4_stray_ignored", {err, busy}, 0);
        tick();
        tick();
        chk("t4_no_done", done_cnt, 2);

        // PW, three channels
        launch(1'b1, 11'd3, 32'h100, 32'h0, 32'h40);
        chk("t5_waddr0", weight_init_addr, 0);
        tick();
        chk("t5_dw_comp", dw_comp, 2'b11);
        run_map(1125);
        tick();
        chk("t5_ch1", {data_init_addr, weight_init_addr}, {32'h140, 32'h4});
        tick();
        run_map(1125);
        tick();
        chk("t5_ch2", {ch_idx, weight_init_addr}, {11'd2, 32'h8});
        tick();
        run_map(1125);
        tick();
        chk("t5_done", {done, err}, 2'b10);
        tick();

        // address wrap and start while busy
        launch(1'b0, 11'd2, 32'hFFFF_FFF0, 32'h0, 32'h20);
        chk("t6_daddr0", data_init_addr, 32'hFFFF_FFF0);
        tick();
        num_ch = 11'd5;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("t6_start_ignored", {busy, data_load, ch_idx}, {2'b11, 11'd0});
        run_map(296);
        tick();
        chk("t6_daddr_wrap", data_init_addr, 32'h0000_0010);
        tick();
        run_map(296);
        tick();
        chk("t6_done", {done, err}, 2'b10);
        tick();

        // async reset mid-run
        launch(1'b1, 11'd2, 32'h500, 32'h600, 32'h10);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_rst", {busy, data_load, dw_comp, err}, 0);
        chk("t7_async_addrs", {data_init_addr, weight_init_addr, 21'(ch_idx)}, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t7_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
